pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It generates per-stage write-enable and bubble controls for the PC, IF/ID, ID/EX (op-read) and EX/MEM latches. It resolves load-use hazards, multicycle execute ops, taken-branch flushes and memory back-pressure. It sits beside the datapath in the pipeline top level and is the only source of latch-advance control.

---
 rtl/pipeline_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, multicycle EX, branch flush, memory freeze.
// Optional build macro PIPE_PERF_EN adds 32-bit stall and flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MC_CYCLES    = 4,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_mc_start,
  input  logic        br_taken,
  input  logic        mem_busy,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        if_id_bubble,
  output logic        id_ex_we,
  output logic        id_ex_bubble,
  output logic        ex_mem_we,
  output logic        ex_mem_bubble,
  output logic        stall,
  output logic        mc_done,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  // state   | meaning
  // RUN     | normal issue; branch, multicycle and load-use decisions made here
  // MC_WAIT | front end held while a multicycle EX op completes; cnt counts down
  // FLUSH   | extra cycles bubbling IF/ID and ID/EX after a taken branch
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MC_LOAD    = CNT_W'(MC_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign lu = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
               (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    if_id_bubble  = 1'b0;
    id_ex_we      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_we     = 1'b1;
    ex_mem_bubble = 1'b0;
    mc_done       = 1'b0;

    if (rst) begin
      state_d       = RUN;
      cnt_d         = '0;
      if_id_bubble  = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_valid && br_taken) begin
            if_id_bubble = 1'b1;
            id_ex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              cnt_d   = FLUSH_LOAD;
            end
          end else if (ex_valid && ex_mc_start) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_bubble = 1'b1;
            state_d       = MC_WAIT;
            cnt_d         = MC_LOAD;
          end else if (lu) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        MC_WAIT: begin
          if (cnt_q != '0) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_bubble = 1'b1;
            cnt_d         = cnt_q - CNT_ONE;
          end else begin
            mc_done = 1'b1;
            state_d = RUN;
          end
        end
        FLUSH: begin
          // EX only holds bubbles here, so any br_taken seen is stale
          if_id_bubble = 1'b1;
          id_ex_bubble = 1'b1;
          if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign stall = ~(pc_we & if_id_we & id_ex_we);

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        br_accept;

  assign br_accept = ~rst & ~mem_busy & (state_q == RUN) & ex_valid & br_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall)     stall_cnt_q <= stall_cnt_q + 32'd1;
      if (br_accept) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (MC_CYCLES=4, FLUSH_CYCLES=2); vector table plus corner sequences.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_valid, ex_is_load, ex_mc_start, br_taken, mem_busy;
  logic        pc_we, if_id_we, if_id_bubble, id_ex_we, id_ex_bubble, ex_mem_we, ex_mem_bubble;
  logic        stall, mc_done;
  logic [31:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MC_CYCLES(4), .FLUSH_CYCLES(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_mc_start(ex_mc_start),
    .br_taken(br_taken), .mem_busy(mem_busy),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_bubble(if_id_bubble),
    .id_ex_we(id_ex_we), .id_ex_bubble(id_ex_bubble),
    .ex_mem_we(ex_mem_we), .ex_mem_bubble(ex_mem_bubble),
    .stall(stall), .mc_done(mc_done), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // {pc_we, if_id_we, if_id_bubble, id_ex_we, id_ex_bubble, ex_mem_we, ex_mem_bubble, stall, mc_done}
  localparam logic [8:0] O_NORM = 9'b1_1_0_1_0_1_0_0_0;
  localparam logic [8:0] O_RST  = 9'b1_1_1_1_1_1_1_0_0;
  localparam logic [8:0] O_BUSY = 9'b0_0_0_0_0_0_0_1_0;
  localparam logic [8:0] O_FLSH = 9'b1_1_1_1_1_1_0_0_0;
  localparam logic [8:0] O_MCST = 9'b0_0_0_0_0_1_1_1_0;
  localparam logic [8:0] O_LU   = 9'b0_0_0_1_1_1_0_1_0;
  localparam logic [8:0] O_DONE = 9'b1_1_0_1_0_1_0_0_1;

  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] rs1, rs2;
    logic       u1, u2, exv;
    logic [4:0] rd;
    logic       ld, mc, br, busy;
    logic [8:0] exp;
    logic       finc;
  } vec_t;

  vec_t        table_v[$];
  vec_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_stall  = 0;
  logic [31:0] m_flush  = 0;

  function automatic vec_t mk(string n, logic r, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic exv, logic [4:0] rd, logic ld, logic mc, logic br, logic busy,
                              logic [8:0] exp, logic finc);
    vec_t v;
    v.name = n; v.rst = r; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.exv = exv;
    v.rd = rd; v.ld = ld; v.mc = mc; v.br = br; v.busy = busy; v.exp = exp; v.finc = finc;
    return v;
  endfunction

  function automatic vec_t idle(string n, logic [8:0] exp);
    return mk(n, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, exp, 0);
  endfunction

  task automatic step(input vec_t v);
    vec_t        e;
    logic [8:0]  got;
    logic [31:0] exp_sc, exp_fc;
    @(posedge clk); #1;
    rst = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
    ex_valid = v.exv; ex_rd = v.rd; ex_is_load = v.ld; ex_mc_start = v.mc;
    br_taken = v.br; mem_busy = v.busy;
    sb_q.push_back(v);
    @(negedge clk);
    e   = sb_q.pop_front();
    got = {pc_we, if_id_we, if_id_bubble, id_ex_we, id_ex_bubble, ex_mem_we, ex_mem_bubble, stall, mc_done};
    n_checks++;
    if (got !== e.exp) begin
      n_fail++;
      $display("FAIL %s: outputs got %b expected %b", e.name, got, e.exp);
    end
    if (!e.rst) begin
`ifdef PIPE_PERF_EN
      exp_sc = m_stall; exp_fc = m_flush;
`else
      exp_sc = 32'd0;   exp_fc = 32'd0;
`endif
      n_checks++;
      if (stall_cnt !== exp_sc || flush_cnt !== exp_fc) begin
        n_fail++;
        $display("FAIL %s_perf: stall_cnt/flush_cnt got %0d/%0d expected %0d/%0d",
                 e.name, stall_cnt, flush_cnt, exp_sc, exp_fc);
      end
    end
    if (e.rst) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (e.exp[1]) m_stall = m_stall + 1;
      if (e.finc)   m_flush = m_flush + 1;
    end
  endtask

  initial begin
    rst = 1; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; ex_valid = 0;
    ex_rd = 0; ex_is_load = 0; ex_mc_start = 0; br_taken = 0; mem_busy = 0;

    table_v.push_back(mk("rst0",      1, 7, 7, 1, 1, 1, 7, 1, 1, 1, 1, O_RST, 0));
    table_v.push_back(mk("rst1",      1, 7, 7, 1, 1, 1, 7, 1, 1, 1, 1, O_RST, 0));
    table_v.push_back(idle("idle", O_NORM));
    table_v.push_back(mk("lu_rs2",    0, 0, 5, 0, 1, 1, 5, 1, 0, 0, 0, O_LU, 0));
    table_v.push_back(idle("after_lu", O_NORM));
    table_v.push_back(mk("lu_r0",     0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, O_NORM, 0));
    table_v.push_back(mk("lu_nouse",  0, 9, 0, 0, 0, 1, 9, 1, 0, 0, 0, O_NORM, 0));
    table_v.push_back(mk("lu_rs1",    0, 31, 0, 1, 0, 1, 31, 1, 0, 0, 0, O_LU, 0));
    table_v.push_back(mk("lu_nvalid", 0, 5, 5, 1, 1, 0, 5, 1, 0, 0, 0, O_NORM, 0));
    table_v.push_back(mk("no_load",   0, 5, 5, 1, 1, 1, 5, 0, 0, 0, 0, O_NORM, 0));
    table_v.push_back(mk("br_nvalid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_NORM, 0));
    table_v.push_back(mk("mc_nvalid", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_NORM, 0));
    table_v.push_back(mk("busy_run",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_BUSY, 0));
    table_v.push_back(mk("br_busy",   0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, O_BUSY, 0));
    table_v.push_back(idle("after_brbusy", O_NORM));
    table_v.push_back(mk("all3",      0, 3, 0, 1, 0, 1, 3, 1, 1, 1, 0, O_FLSH, 1));
    table_v.push_back(idle("flush2", O_FLSH));
    table_v.push_back(idle("post_flush", O_NORM));
    foreach (table_v[i]) step(table_v[i]);

    // multicycle: 4 stall cycles, mid-wait br/mc/lu ignored, then mc_done
    step(mk("mc_start", 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, O_MCST, 0));
    step(idle("mc_w1", O_MCST));
    step(mk("mc_w2_br", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, O_MCST, 0));
    step(mk("mc_w3_lu", 0, 4, 0, 1, 0, 1, 4, 1, 1, 0, 0, O_MCST, 0));
    step(idle("mc_done", O_DONE));
    step(idle("mc_post", O_NORM));

    // mem_busy freezes MC_WAIT at cnt=2 for 3 cycles
    step(mk("mcb_start", 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, O_MCST, 0));
    step(idle("mcb_w1", O_MCST));
    for (int i = 0; i < 3; i++)
      step(mk("mcb_busy", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, O_BUSY, 0));
    step(idle("mcb_w2", O_MCST));
    step(idle("mcb_w3", O_MCST));
    step(idle("mcb_done", O_DONE));
    step(idle("mcb_post", O_NORM));

    // branch in FLUSH is not accepted; busy during FLUSH holds it
    step(mk("fl_br", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, O_FLSH, 1));
    step(mk("fl_br2", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, O_FLSH, 0));
    step(idle("fl_post", O_NORM));
    step(mk("flb_br", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, O_FLSH, 1));
    step(mk("flb_busy", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_BUSY, 0));
    step(idle("flb_fl", O_FLSH));
    step(idle("flb_post", O_NORM));

    // reset aborts MC_WAIT
    step(mk("ab_start", 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, O_MCST, 0));
    step(mk("ab_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 0));
    step(idle("ab_post", O_NORM));
    step(idle("ab_post2", O_NORM));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
